// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the multicycle RV32I core. It takes the decode fields from the
// instruction register and the ALU flags, and drives the datapath mux selects
// and write enables. It also covers the full RV32I control flow, a memory
// request/ready handshake with wait states, a halt state for SYSTEM and
// illegal opcodes, and a retired-instruction counter.
//
// Parameters:
//   MEM_HANDSHAKE   : 1 = honour mem_ready, 0 = treat mem_ready as always 1
//   TRAP_ON_ILLEGAL : 1 = unknown opcode halts, 0 = unknown opcode is a NOP
//   CNT_W           : width of the instret counter
//
// Ports:
//   clk                  in   rising-edge clock
//   rst                  in   synchronous active-low reset
//   opcode, funct3       in   instruction register fields
//   zero, lt, ltu        in   ALU flags (equal, signed lt, unsigned lt)
//   mem_ready            in   memory finishes the access this cycle
//   PCWrite, IRWrite     out  PC / IR write enables
//   RegWrite, MemWrite   out  register file / memory write enables
//   mem_req              out  memory access request
//   AdrSrc               out  memory address select (0 PC, 1 ALUOut)
//   ResultSrc            out  result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA              out  ALU A mux (00 PC, 01 oldPC, 10 rs1, 11 zero)
//   ALUSrcB              out  ALU B mux (00 rs2, 01 imm, 10 const 4)
//   alu_op               out  00 add, 01 sub/compare, 10 funct-decoded
//   halt                 out  core stopped in HALT
//   state                out  current state, for debug
//   instret              out  retired-instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       alu_op,
    output logic             halt,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_CALC = 4'd11,
        S_JALR      = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;

    logic       w_ready;
    logic       w_taken;
    logic       w_retire;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_mem_req;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;

    // With the handshake disabled every memory access completes in one cycle.
    assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Branch condition from funct3; 010/011 are not branch encodings.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // Next-state and Moore outputs; FETCH enables and BRANCH PCWrite are the
    // only outputs that also look at this cycle's inputs.
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = w_ready;
                w_ir_write   = w_ready;
                if (w_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (opcode)
                    OP_R:                w_next = S_EXEC_R;
                    OP_I:                w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:   w_next = S_MEM_ADDR;
                    OP_BRANCH:           w_next = S_BRANCH;
                    OP_JAL:              w_next = S_JAL;
                    OP_JALR:             w_next = S_JALR_CALC;
                    OP_LUI:              w_next = S_LUI;
                    OP_AUIPC:            w_next = S_AUIPC;
                    OP_FENCE:            w_next = S_FETCH;
                    OP_SYSTEM:           w_next = S_HALT;
                    default:             w_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_LUI: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b01;
                w_next      = S_ALU_WB;
            end
            S_AUIPC: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_next      = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (w_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b01;
                w_pc_write  = w_taken;
                w_next      = S_FETCH;
            end
            S_JAL, S_JALR: begin
                // Target already sits in ALUOut; ALU computes the link PC+4.
                w_pc_write  = 1'b1;
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_JALR_CALC: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = S_JALR;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    // An instruction retires on the edge that brings the FSM back to FETCH
    // from one of its terminal states (FETCH waiting on itself excluded).
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_DECODE});

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others; reset is sampled on the edge.
        if (!rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Enables are held low for the whole reset cycle, whatever state is current.
    assign PCWrite   = w_pc_write  & rst;
    assign IRWrite   = w_ir_write  & rst;
    assign RegWrite  = w_reg_write & rst;
    assign MemWrite  = w_mem_write & rst;
    assign mem_req   = w_mem_req   & rst;
    assign AdrSrc    = w_adr_src;
    assign ResultSrc = w_result_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign alu_op    = w_alu_op;
    assign halt      = (r_state == S_HALT);
    assign state     = r_state;
    assign instret   = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. A table of per-cycle {inputs, expected
// outputs} records drives the default-parameter instance through every
// instruction class. Hand-written sequences cover halt/reset, reset during a
// memory wait, the no-handshake variant, the non-trapping variant and the
// counter wrap with a 4-bit instret.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_ILL   = 7'b0000000;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, lt, ltu, rdy;
    } in_t;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, rw, mw, req, adr;
        logic [1:0]  rs, a, b, aop;
        logic        hlt;
        logic [31:0] ir;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

    // Default instance
    logic        PCWrite, IRWrite, RegWrite, MemWrite, mem_req, AdrSrc, halt;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, alu_op;
    logic [3:0]  state;
    logic [31:0] instret;
    // TRAP_ON_ILLEGAL = 0
    logic        nt_pcw, nt_irw, nt_rw, nt_mw, nt_req, nt_adr, nt_halt;
    logic [1:0]  nt_rs, nt_a, nt_b, nt_aop;
    logic [3:0]  nt_state;
    logic [31:0] nt_instret;
    // CNT_W = 4
    logic        c4_pcw, c4_irw, c4_rw, c4_mw, c4_req, c4_adr, c4_halt;
    logic [1:0]  c4_rs, c4_a, c4_b, c4_aop;
    logic [3:0]  c4_state;
    logic [3:0]  c4_instret;
    // MEM_HANDSHAKE = 0
    logic        nh_pcw, nh_irw, nh_rw, nh_mw, nh_req, nh_adr, nh_halt;
    logic [1:0]  nh_rs, nh_a, nh_b, nh_aop;
    logic [3:0]  nh_state;
    logic [31:0] nh_instret;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .alu_op(alu_op), .halt(halt), .state(state), .instret(instret)
    );

    multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(nt_pcw), .IRWrite(nt_irw), .RegWrite(nt_rw), .MemWrite(nt_mw),
        .mem_req(nt_req), .AdrSrc(nt_adr), .ResultSrc(nt_rs), .ALUSrcA(nt_a),
        .ALUSrcB(nt_b), .alu_op(nt_aop), .halt(nt_halt), .state(nt_state), .instret(nt_instret)
    );

    multicycle_ctrl #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(c4_pcw), .IRWrite(c4_irw), .RegWrite(c4_rw), .MemWrite(c4_mw),
        .mem_req(c4_req), .AdrSrc(c4_adr), .ResultSrc(c4_rs), .ALUSrcA(c4_a),
        .ALUSrcB(c4_b), .alu_op(c4_aop), .halt(c4_halt), .state(c4_state), .instret(c4_instret)
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(nh_pcw), .IRWrite(nh_irw), .RegWrite(nh_rw), .MemWrite(nh_mw),
        .mem_req(nh_req), .AdrSrc(nh_adr), .ResultSrc(nh_rs), .ALUSrcA(nh_a),
        .ALUSrcB(nh_b), .alu_op(nh_aop), .halt(nh_halt), .state(nh_state), .instret(nh_instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    // Branch sweep: funct3, flags and the hand-derived taken result.
    bit [2:0] br_f3  [9] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3};
    bit       br_z   [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    bit       br_lt  [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    bit       br_ltu [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit       br_tk  [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic out_t cap();
        out_t o;
        o = '{state, PCWrite, IRWrite, RegWrite, MemWrite, mem_req, AdrSrc,
              ResultSrc, ALUSrcA, ALUSrcB, alu_op, halt, instret};
        return o;
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic z, input logic l, input logic lu, input logic rdy,
                                input logic [3:0] st, input logic pcw, input logic irw,
                                input logic rw, input logic mw, input logic req, input logic adr,
                                input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] aop, input logic hlt, input int ir);
        vec_t v;
        v.i = '{op, f3, z, l, lu, rdy};
        v.o = '{st, pcw, irw, rw, mw, req, adr, rs, a, b, aop, hlt, ir[31:0]};
        return v;
    endfunction

    function automatic vec_t fetch(input logic [6:0] op, input logic rdy, input int ir);
        return mk(op, 3'd0, 0, 0, 0, rdy, 4'd0, rdy, rdy, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, ir);
    endfunction

    function automatic vec_t dec(input logic [6:0] op, input logic [2:0] f3, input logic rdy, input int ir);
        return mk(op, f3, 0, 0, 0, rdy, 4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, ir);
    endfunction

    function automatic vec_t alu_wb(input logic [6:0] op, input logic rdy, input int ir);
        return mk(op, 3'd0, 0, 0, 0, rdy, 4'd8, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, ir);
    endfunction

    task automatic drive(input in_t v);
        @(negedge clk);
        rst       = 1'b1;
        opcode    = v.op;
        funct3    = v.f3;
        zero      = v.z;
        lt        = v.lt;
        ltu       = v.ltu;
        mem_ready = v.rdy;
        #1;
    endtask

    task automatic cyc(input logic [6:0] op, input logic rdy);
        drive('{op, 3'd0, 1'b0, 1'b0, 1'b0, rdy});
    endtask

    // Holds rst low across the next rising edge; the caller's next drive
    // releases it, so the first cycle after this task is FETCH.
    task automatic reset_all();
        @(negedge clk);
        rst       = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b1;
        #1;
        check("reset forces enables low",
              {59'd0, PCWrite, IRWrite, RegWrite, MemWrite, mem_req}, 64'd0);
    endtask

    initial begin
        // Watchdog: the bench is purely cycle-driven, this only guards a hang.
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ir;

        // ---- Table: default instance, one record per cycle ----
        // R-type add
        vecs.push_back(fetch(OP_R, 1, 0));
        vecs.push_back(dec(OP_R, 3'd0, 1, 0));
        vecs.push_back(mk(OP_R, 3'd0, 0, 0, 0, 1, 4'd6, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0));
        vecs.push_back(alu_wb(OP_R, 1, 0));
        // Load, two wait cycles in MEM_READ
        vecs.push_back(fetch(OP_LD, 1, 1));
        vecs.push_back(dec(OP_LD, 3'd2, 1, 1));
        vecs.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 1));
        vecs.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 1, 4'd3, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1));
        vecs.push_back(mk(OP_LD, 3'd2, 0, 0, 0, 1, 4'd4, 0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 0, 1));
        // Store, one wait in FETCH and one in MEM_WRITE
        vecs.push_back(fetch(OP_ST, 0, 2));
        vecs.push_back(fetch(OP_ST, 1, 2));
        vecs.push_back(dec(OP_ST, 3'd2, 1, 2));
        vecs.push_back(mk(OP_ST, 3'd2, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 2));
        vecs.push_back(mk(OP_ST, 3'd2, 0, 0, 0, 0, 4'd5, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2));
        vecs.push_back(mk(OP_ST, 3'd2, 0, 0, 0, 1, 4'd5, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 2));
        // Branch sweep
        for (int k = 0; k < 9; k++) begin
            ir = 3 + k;
            vecs.push_back(fetch(OP_BR, 1, ir));
            vecs.push_back(dec(OP_BR, br_f3[k], 1, ir));
            vecs.push_back(mk(OP_BR, br_f3[k], br_z[k], br_lt[k], br_ltu[k], 1,
                              4'd9, br_tk[k], 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 0, ir));
        end
        // JAL, mem_ready low outside memory states must not matter
        vecs.push_back(fetch(OP_JAL, 1, 12));
        vecs.push_back(dec(OP_JAL, 3'd0, 0, 12));
        vecs.push_back(mk(OP_JAL, 3'd0, 0, 0, 0, 0, 4'd10, 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 12));
        vecs.push_back(alu_wb(OP_JAL, 0, 12));
        // JALR
        vecs.push_back(fetch(OP_JALR, 1, 13));
        vecs.push_back(dec(OP_JALR, 3'd0, 1, 13));
        vecs.push_back(mk(OP_JALR, 3'd0, 0, 0, 0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 13));
        vecs.push_back(mk(OP_JALR, 3'd0, 0, 0, 0, 1, 4'd12, 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 13));
        vecs.push_back(alu_wb(OP_JALR, 1, 13));
        // LUI
        vecs.push_back(fetch(OP_LUI, 1, 14));
        vecs.push_back(dec(OP_LUI, 3'd0, 1, 14));
        vecs.push_back(mk(OP_LUI, 3'd0, 0, 0, 0, 1, 4'd13, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 2'd0, 0, 14));
        vecs.push_back(alu_wb(OP_LUI, 1, 14));
        // AUIPC
        vecs.push_back(fetch(OP_AUIPC, 1, 15));
        vecs.push_back(dec(OP_AUIPC, 3'd0, 1, 15));
        vecs.push_back(mk(OP_AUIPC, 3'd0, 0, 0, 0, 1, 4'd14, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, 15));
        vecs.push_back(alu_wb(OP_AUIPC, 1, 15));
        // I-type ALU
        vecs.push_back(fetch(OP_I, 1, 16));
        vecs.push_back(dec(OP_I, 3'd0, 1, 16));
        vecs.push_back(mk(OP_I, 3'd0, 0, 0, 0, 1, 4'd7, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2, 0, 16));
        vecs.push_back(alu_wb(OP_I, 1, 16));
        // FENCE retires straight from DECODE
        vecs.push_back(fetch(OP_FENCE, 1, 17));
        vecs.push_back(dec(OP_FENCE, 3'd0, 1, 17));
        // SYSTEM halts, instret stays
        vecs.push_back(fetch(OP_SYS, 1, 18));
        vecs.push_back(dec(OP_SYS, 3'd0, 1, 18));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(OP_SYS, 3'd0, 0, 0, 0, 1, 4'd15, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 18));

        reset_all();
        foreach (vecs[k]) begin
            drive(vecs[k].i);
            check($sformatf("row %0d state=%0d", k, state), {13'd0, cap()}, {13'd0, vecs[k].o});
        end

        // ---- Illegal opcode: trapping vs non-trapping instance ----
        reset_all();
        cyc(OP_ILL, 1);
        check("reset state/instret/halt", {27'd0, state, halt, instret}, 64'd0);
        cyc(OP_ILL, 1);
        check("illegal decode state", {60'd0, state}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            cyc(OP_ILL, 1);
            check($sformatf("illegal halt hold %0d", k), {27'd0, state, halt, instret},
                  {27'd0, 4'd15, 1'b1, 32'd0});
            if (k == 0)
                check("no-trap illegal returns to fetch", {28'd0, nt_state, nt_instret},
                      {28'd0, 4'd0, 32'd1});
        end
        reset_all();
        cyc(OP_R, 1);
        check("reset from halt", {27'd0, state, halt, instret}, 64'd0);

        // ---- Reset during a MEM_READ wait ----
        cyc(OP_R, 1);
        reset_all();
        cyc(OP_LD, 1);
        cyc(OP_LD, 1);
        cyc(OP_LD, 1);
        cyc(OP_LD, 0);
        check("mem_read wait", {58'd0, state, mem_req, AdrSrc}, {58'd0, 4'd3, 1'b1, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset gates mem_req mid-wait", {59'd0, state, mem_req}, {59'd0, 4'd3, 1'b0});
        cyc(OP_LD, 0);
        check("reset mid-wait back to fetch", {27'd0, state, IRWrite, instret}, 64'd0);

        // ---- No-handshake instance: memory states last one cycle ----
        reset_all();
        for (int k = 0; k < 6; k++) begin
            logic [3:0] exp_st;
            exp_st = (k == 5) ? 4'd0 : 4'(k);
            cyc(OP_LD, 0);
            check($sformatf("no-handshake load state %0d", k), {60'd0, nh_state}, {60'd0, exp_st});
            if (k == 0)
                check("no-handshake fetch enables", {62'd0, nh_irw, nh_pcw}, 64'd3);
            if (k == 2)
                check("handshake instance stalls in fetch", {59'd0, state, IRWrite}, 64'd0);
        end
        check("no-handshake load retired", {32'd0, nh_instret}, 64'd1);

        // ---- 4-bit instret wrap over 16 FENCEs ----
        reset_all();
        for (int k = 0; k <= 16; k++) begin
            cyc(OP_FENCE, 1);
            check($sformatf("instret4 after %0d fences", k), {60'd0, c4_instret}, {60'd0, 4'(k % 16)});
            if (k < 16) cyc(OP_FENCE, 1);
        end
        check("instret32 after 16 fences", {32'd0, instret}, 64'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control FSM for the multicycle RV32I core. It drives the same datapath select and enable signals as the current main FSM. It adds full RV32I control flow (JALR, AUIPC, all six branches), a memory ready/request handshake with wait states, an illegal/system halt state, and a retired-instruction counter. It sits between the instruction register decode fields and the datapath muxes and enables.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = honour `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `TRAP_ON_ILLEGAL`, default 1: 1 = unknown opcode enters HALT; 0 = unknown opcode returns to FETCH (treated as NOP).
- `CNT_W`, default 32: width of `instret`.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset; one clock, synchronous reset, active-low.
- `opcode` in 7, `funct3` in 3: fields from the instruction register.
- `zero`, `lt`, `ltu` in 1: ALU flags for the current cycle's operands (equal, signed less-than, unsigned less-than).
- `mem_ready` in 1: memory completes the access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1: datapath enables.
- `mem_req` out 1: memory access request.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2: 00 = rs2, 01 = imm, 10 = const 4.
- `alu_op` out 2: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- `halt` out 1: core stopped in HALT.
- `state` out 4: current state, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation
State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR_CALC=11, JALR=12, LUI=13, AUIPC=14, HALT=15.

Per-state outputs and transitions (outputs not listed are 0):
- **FETCH:** `mem_req`=1, `AdrSrc`=0, A=00, B=10, add, `ResultSrc`=10. `IRWrite` and `PCWrite` equal the effective `mem_ready`. The FSM stays in FETCH until the effective `mem_ready` is 1, then goes to DECODE.
- **DECODE:** A=01, B=01, add (branch/JAL target into ALUOut). Next state by opcode:
  - R → EXEC_R
  - I-ALU → EXEC_I
  - load/store → MEM_ADDR
  - branch → BRANCH
  - JAL → JAL
  - JALR (1100111) → JALR_CALC
  - LUI → LUI
  - AUIPC (0010111) → AUIPC
  - FENCE (0001111) → FETCH, retires
  - SYSTEM (1110011) → HALT
  - other → HALT if `TRAP_ON_ILLEGAL`, else FETCH (retires)
- **EXEC_R:** A=10, B=00, alu_op 10 → ALU_WB.
- **EXEC_I:** A=10, B=01, alu_op 10 → ALU_WB.
- **LUI:** A=11, B=01, add → ALU_WB.
- **AUIPC:** A=01, B=01, add → ALU_WB.
- **MEM_ADDR:** A=10, B=01, add → MEM_WRITE if store, else MEM_READ.
- **MEM_READ:** `mem_req`=1, `AdrSrc`=1. Stays until the effective `mem_ready`, then → MEM_WB.
- **MEM_WB:** `ResultSrc`=01, `RegWrite` → FETCH.
- **MEM_WRITE:** `mem_req`=1, `AdrSrc`=1, `MemWrite`=1, held until the effective `mem_ready`, then → FETCH.
- **ALU_WB:** `ResultSrc`=00, `RegWrite` → FETCH.
- **BRANCH:** A=10, B=00, alu_op 01, `ResultSrc`=00. `PCWrite` = taken, where taken by funct3 is:
  - 000: `zero`
  - 001: `!zero`
  - 100: `lt`
  - 101: `!lt`
  - 110: `ltu`
  - 111: `!ltu`
  - 010/011: never taken
  
  Then → FETCH.
- **JAL:** `PCWrite`, `ResultSrc`=00 (target), A=01, B=10, add (link) → ALU_WB.
- **JALR_CALC:** A=10, B=01, add → JALR.
- **JALR:** `PCWrite`, `ResultSrc`=00, A=01, B=10, add → ALU_WB. Clearing target bit 0 is done by the datapath.
- **HALT:** `halt`=1, all enables 0, stays in HALT until reset.

Retirement:
- `instret` increments by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE, BRANCH or DECODE.
- Wraps modulo 2^CNT_W.

## Timing
- **Reset:** `rst`=0 at a rising edge sets `state`=FETCH, `instret`=0, `halt`=0. While `rst`=0, `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `mem_req` are forced 0. Reset overrides any state, including a mid-wait memory access or HALT.
- **Output types:** outputs are Moore, except for two Mealy (same-cycle) outputs:
  - FETCH `IRWrite`/`PCWrite`, gated by `mem_ready`.
  - BRANCH `PCWrite`, from the flags.
- **Zero-wait latencies:** R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5, FENCE 2. Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- **`mem_ready` outside FETCH/MEM_READ/MEM_WRITE:** ignored.
- **`MEM_HANDSHAKE`=0:** memory states always last exactly one cycle.

## Test plan
- **R-type `add`, `mem_ready`=1:** states 0,1,6,8,0. `RegWrite` only in the ALU_WB cycle. `instret` 0→1.
- **Load with `mem_ready` low 2 cycles in MEM_READ:** MEM_READ lasts 3 cycles with `mem_req`=1 and `AdrSrc`=1. Then MEM_WB with `ResultSrc`=01 and `RegWrite`=1. Total 7 cycles.
- **Branch sweep (all six funct3 values) with `lt`=1, `ltu`=0, `zero`=0:** `PCWrite`=1 for bne, blt, bgeu; `PCWrite`=0 for beq, bge, bltu. Each instruction takes 3 cycles.
- **JALR:** states 1,11,12,8. `PCWrite` in JALR with `ResultSrc`=00. ALU_WB `RegWrite`=1.
- **Illegal opcode 0000000, `TRAP_ON_ILLEGAL`=1:** DECODE→HALT, `halt`=1 and `state`=15 held 10 cycles, `instret` unchanged. Then `rst`=0 for one edge returns to FETCH with `instret`=0. With `TRAP_ON_ILLEGAL`=0, the same opcode returns to FETCH and `instret` increments.
- **`CNT_W`=4, 16 FENCE instructions:** `instret` wraps 15→0.
